// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: prefetching instruction-fetch stage.
// Issues sequential word fetches to a request/grant instruction memory and
// buffers the returned words with their PCs in a small FIFO. The core takes
// them over a valid/ready handshake. A redirect flushes the FIFO and marks
// every in-flight response for discard.
module instr_fetch_queue #(
  parameter int                ADDR_W   = 64,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              instr_valid_o,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  input  logic              instr_ready_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CRD_W = PTR_W + 2;

  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0]  PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]  PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [CRD_W-1:0]  CRD_DEPTH = CRD_W'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP   = {{(ADDR_W-3){1'b0}}, 3'b100};
  localparam logic [ADDR_W-1:0] PC_ZERO   = {ADDR_W{1'b0}};

  // Architectural state
  logic [ADDR_W-1:0] fetch_pc_r;
  logic [ADDR_W-1:0] resp_pc_r;
  logic [CNT_W-1:0]  inflight_r;
  logic [CNT_W-1:0]  drop_r;
  logic [CNT_W-1:0]  count_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [ADDR_W-1:0] pc_store_r    [DEPTH];
  logic [31:0]       instr_store_r [DEPTH];

  // Per-cycle decoded events
  logic              credit_ok_s;
  logic              mem_req_s;
  logic              grant_s;
  logic              resp_s;
  logic              push_s;
  logic              pop_s;
  logic [ADDR_W-1:0] target_pc_s;
  logic [CNT_W-1:0]  inflight_next_s;
  logic [CNT_W-1:0]  drop_next_s;
  logic [CNT_W-1:0]  count_next_s;

  // Low address bits of the redirect target are deliberately ignored.
  logic unused_pc_bits_s;
  assign unused_pc_bits_s = ^redirect_pc_i[1:0];

  // Credit, request, and the events that move the queue this cycle.
  always_comb begin
    credit_ok_s = 1'b0;
    mem_req_s   = 1'b0;
    grant_s     = 1'b0;
    resp_s      = 1'b0;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    target_pc_s = {redirect_pc_i[ADDR_W-1:2], 2'b00};

    // Credit comes only from registered occupancy, so a pop or response
    // in this cycle frees a slot from the next cycle onwards.
    if (({1'b0, count_r} + {1'b0, inflight_r}) < CRD_DEPTH) begin
      credit_ok_s = 1'b1;
    end else begin
      credit_ok_s = 1'b0;
    end

    // Held low throughout reset and during a redirect cycle.
    if (rst_i && !redirect_i && credit_ok_s) begin
      mem_req_s = 1'b1;
    end else begin
      mem_req_s = 1'b0;
    end

    grant_s = mem_req_s && mem_gnt_i;

    // An rvalid with nothing outstanding is a protocol error and is ignored.
    if (mem_rvalid_i && (inflight_r != CNT_ZERO)) begin
      resp_s = 1'b1;
    end else begin
      resp_s = 1'b0;
    end

    // A redirect overrides both ends of the FIFO.
    if (redirect_i) begin
      push_s = 1'b0;
      pop_s  = 1'b0;
    end else begin
      push_s = resp_s && (drop_r == CNT_ZERO);
      pop_s  = (count_r != CNT_ZERO) && instr_ready_i;
    end
  end

  // Next-state arithmetic for the in-flight, drop and occupancy counters.
  always_comb begin
    inflight_next_s = inflight_r;
    drop_next_s     = drop_r;
    count_next_s    = count_r;

    if (redirect_i) begin
      // Everything still outstanding after this cycle is stale.
      if (resp_s) begin
        inflight_next_s = inflight_r - CNT_ONE;
      end else begin
        inflight_next_s = inflight_r;
      end
      drop_next_s  = inflight_next_s;
      count_next_s = CNT_ZERO;
    end else begin
      case ({grant_s, resp_s})
        2'b10:   inflight_next_s = inflight_r + CNT_ONE;
        2'b01:   inflight_next_s = inflight_r - CNT_ONE;
        default: inflight_next_s = inflight_r;
      endcase

      if (resp_s && (drop_r != CNT_ZERO)) begin
        drop_next_s = drop_r - CNT_ONE;
      end else begin
        drop_next_s = drop_r;
      end

      case ({push_s, pop_s})
        2'b10:   count_next_s = count_r + CNT_ONE;
        2'b01:   count_next_s = count_r - CNT_ONE;
        default: count_next_s = count_r;
      endcase
    end
  end

  // Fetch and response PC tracking; both restart at the redirect target.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_pc_r <= RESET_PC;
      resp_pc_r  <= RESET_PC;
    end else if (redirect_i) begin
      fetch_pc_r <= target_pc_s;
      resp_pc_r  <= target_pc_s;
    end else begin
      if (grant_s) begin
        fetch_pc_r <= fetch_pc_r + PC_STEP;
      end
      if (push_s) begin
        resp_pc_r <= resp_pc_r + PC_STEP;
      end
    end
  end

  // Outstanding-request, discard and occupancy counters.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      inflight_r <= CNT_ZERO;
      drop_r     <= CNT_ZERO;
      count_r    <= CNT_ZERO;
    end else begin
      inflight_r <= inflight_next_s;
      drop_r     <= drop_next_s;
      count_r    <= count_next_s;
    end
  end

  // FIFO pointers; a flush empties the queue by moving rd_ptr onto wr_ptr.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_ptr_r <= PTR_ZERO;
      wr_ptr_r <= PTR_ZERO;
    end else if (redirect_i) begin
      rd_ptr_r <= wr_ptr_r;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // FIFO storage of {pc, instr}; cleared on reset so outputs start at zero.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_store_r[i]    <= PC_ZERO;
        instr_store_r[i] <= 32'h0000_0000;
      end
    end else if (push_s) begin
      pc_store_r[wr_ptr_r]    <= resp_pc_r;
      instr_store_r[wr_ptr_r] <= mem_rdata_i;
    end
  end

  assign mem_req_o     = mem_req_s;
  assign mem_addr_o    = fetch_pc_r;
  assign instr_valid_o = (count_r != CNT_ZERO);
  assign instr_o       = instr_store_r[rd_ptr_r];
  assign instr_pc_o    = pc_store_r[rd_ptr_r];

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Testbench for instr_fetch_queue: directed scenarios followed by a random
// phase, all compared each cycle against a request-tagging reference model.
module tb_instr_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        redirect_i = 1'b0;
  logic [63:0] redirect_pc_i = 64'h0;
  logic        mem_req_o;
  logic [63:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [63:0] instr_pc_o;
  logic        instr_ready_i = 1'b0;

  instr_fetch_queue #(.ADDR_W(64), .DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .instr_ready_i(instr_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { logic [63:0] pc; bit stale; } req_t;
  typedef struct { logic [31:0] data; int due; } mresp_t;

  ent_t   m_fifo[$];   // instructions the consumer should see, in order
  req_t   m_infl[$];   // granted requests, tagged stale when flushed
  mresp_t mem_q[$];    // memory's pending responses
  logic [63:0] m_fetch_pc;
  int cyc = 0;
  int mem_lat = 1;
  int checks = 0;
  int errors = 0;
  int grants_seen = 0;

  function automatic logic [31:0] data_fn(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drops rst_i away from a clock edge, checks reset outputs, then releases.
  task automatic apply_reset();
    #2;
    rst_i = 1'b0;
    redirect_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; instr_ready_i = 1'b0;
    #1;
    chk("rst_mem_req", {63'h0, mem_req_o}, 64'h0);
    chk("rst_mem_addr", mem_addr_o, 64'h0);
    chk("rst_instr_valid", {63'h0, instr_valid_o}, 64'h0);
    chk("rst_instr", {32'h0, instr_o}, 64'h0);
    chk("rst_instr_pc", instr_pc_o, 64'h0);
    m_fifo.delete(); m_infl.delete(); mem_q.delete();
    m_fetch_pc = 64'h0;
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
  endtask

  // One clock cycle: drive inputs, check DUT against model, advance model.
  task automatic step(input bit redir, input logic [63:0] rpc, input bit gnt, input bit rdy);
    bit   exp_req, exp_valid, rv;
    req_t r;
    @(negedge clk);
    redirect_i = redir; redirect_pc_i = rpc; mem_gnt_i = gnt; instr_ready_i = rdy;
    rv = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
    mem_rvalid_i = rv;
    mem_rdata_i  = rv ? mem_q[0].data : $urandom;
    #1;
    exp_req   = !redir && ((m_fifo.size() + m_infl.size()) < DEPTH);
    exp_valid = (m_fifo.size() != 0);
    chk("mem_req", {63'h0, mem_req_o}, {63'h0, exp_req});
    chk("mem_addr", mem_addr_o, m_fetch_pc);
    chk("instr_valid", {63'h0, instr_valid_o}, {63'h0, exp_valid});
    if (exp_valid) begin
      chk("instr_pc", instr_pc_o, m_fifo[0].pc);
      chk("instr", {32'h0, instr_o}, {32'h0, m_fifo[0].instr});
    end
    // memory reacts to what the DUT actually did
    if (rv) void'(mem_q.pop_front());
    if (mem_req_o && gnt) begin
      grants_seen++;
      mem_q.push_back('{data_fn(mem_addr_o), cyc + mem_lat});
    end
    // reference model
    if (redir) begin
      if (rv && m_infl.size() != 0) void'(m_infl.pop_front());
      foreach (m_infl[i]) m_infl[i].stale = 1'b1;
      m_fifo.delete();
      m_fetch_pc = {rpc[63:2], 2'b00};
    end else begin
      if (exp_valid && rdy) void'(m_fifo.pop_front());
      if (rv && m_infl.size() != 0) begin
        r = m_infl.pop_front();
        if (!r.stale) m_fifo.push_back('{r.pc, data_fn(r.pc)});
      end
      if (exp_req && gnt) begin
        m_infl.push_back('{m_fetch_pc, 1'b0});
        m_fetch_pc = m_fetch_pc + 64'd4;
      end
    end
    cyc++;
  endtask

  initial begin
    logic [63:0] rpc;
    // reset release, 1-cycle memory, always-ready consumer
    apply_reset();
    mem_lat = 1;
    repeat (12) step(1'b0, 64'h0, 1'b1, 1'b1);

    // stalled consumer: exactly DEPTH grants, then drain and resume
    apply_reset();
    grants_seen = 0;
    repeat (10) step(1'b0, 64'h0, 1'b1, 1'b0);
    chk("grants_while_stalled", 64'(grants_seen), 64'd4);
    repeat (8) step(1'b0, 64'h0, 1'b1, 1'b1);

    // 3-cycle memory, 3 requests in flight, then redirect to 0x100
    apply_reset();
    mem_lat = 3;
    repeat (3) step(1'b0, 64'h0, 1'b1, 1'b1);
    step(1'b1, 64'h100, 1'b1, 1'b1);
    repeat (14) step(1'b0, 64'h0, 1'b1, 1'b1);

    // redirect while a response and a pop happen in the same cycle
    mem_lat = 1;
    repeat (6) step(1'b0, 64'h0, 1'b1, 1'b1);
    step(1'b1, 64'h40, 1'b1, 1'b1);
    repeat (6) step(1'b0, 64'h0, 1'b1, 1'b1);

    // unaligned target is forced to a word boundary
    step(1'b1, 64'h103, 1'b1, 1'b1);
    repeat (5) step(1'b0, 64'h0, 1'b1, 1'b1);

    // address wrap-around
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 1'b1);
    repeat (8) step(1'b0, 64'h0, 1'b1, 1'b1);

    // back-to-back redirects with slow memory
    mem_lat = 3;
    repeat (3) step(1'b0, 64'h0, 1'b1, 1'b1);
    step(1'b1, 64'h200, 1'b1, 1'b1);
    step(1'b1, 64'h300, 1'b1, 1'b1);
    repeat (10) step(1'b0, 64'h0, 1'b1, 1'b1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      mem_lat = $urandom_range(1, 4);
      rpc = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      step($urandom_range(0, 15) == 0, rpc, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end

    // fill the FIFO, then reset mid-stream and restart
    mem_lat = 1;
    repeat (8) step(1'b0, 64'h0, 1'b1, 1'b0);
    apply_reset();
    repeat (8) step(1'b0, 64'h0, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
